// File: rtl/cap_core.sv
// -----------------------------------------------------------------------------
// cap_core: content-addressable parallel processor core.
//
// A NUM_CELLS x NUM_BITS word array with one tag bit per cell, driven by a
// single valid/ready command port. Commands set/clear/narrow the tags, pick the
// first tagged cell, write masked data into every tagged cell, or read back the
// lowest-index tagged word. SEARCH takes two cycles (match register stage, then
// tag update); everything else completes in the accepting cycle.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command accepted when cmd_valid & cmd_ready (combinational)
//   cmd_op     opcode (0 NOP, 1 SET_TAGS, 2 CLR_TAGS, 3 SEARCH, 4 SELECT_FIRST,
//              5 WRITE, 6 READ, 7 reserved)
//   cmd_data   comparand / write value
//   cmd_mask   bit mask, 1 = bit participates
//   rsp_valid  one-cycle response pulse (SEARCH and READ only)
//   rsp_hit    any tag set after SEARCH / READ found a cell (held between pulses)
//   rsp_data   read word, 0 for SEARCH (held between pulses)
//   rsp_count  popcount of tags at the response (held), or 0 when not built
//   tag_wires  tag register, bit i = cell i
//   busy       SEARCH update stage in progress
//
// Build option:
//   CAP_MATCH_COUNT_EN  when defined, rsp_count carries the tag popcount
//                       registered with each rsp_valid pulse; otherwise no
//                       popcount logic is built and rsp_count is tied to 0.
// -----------------------------------------------------------------------------
module cap_core #(
    parameter int unsigned  NUM_BITS  = 32,
    parameter int unsigned  NUM_CELLS = 100,
    localparam int unsigned CNT_W     = $clog2(NUM_CELLS + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [NUM_BITS-1:0]  cmd_data,
    input  logic [NUM_BITS-1:0]  cmd_mask,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [NUM_BITS-1:0]  rsp_data,
    output logic [CNT_W-1:0]     rsp_count,
    output logic [NUM_CELLS-1:0] tag_wires,
    output logic                 busy
);

    localparam logic [2:0] OpNop      = 3'd0;
    localparam logic [2:0] OpSetTags  = 3'd1;
    localparam logic [2:0] OpClrTags  = 3'd2;
    localparam logic [2:0] OpSearch   = 3'd3;
    localparam logic [2:0] OpSelFirst = 3'd4;
    localparam logic [2:0] OpWrite    = 3'd5;
    localparam logic [2:0] OpRead     = 3'd6;

    typedef enum logic [0:0] {StIdle, StUpd} state_e;

    state_e               state_q, state_d;
    logic [NUM_CELLS-1:0] tags_q, tags_d;
    logic [NUM_CELLS-1:0] match_q, match_d;
    logic [NUM_BITS-1:0]  cells_q [NUM_CELLS];
    logic [NUM_BITS-1:0]  cells_d [NUM_CELLS];
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_hit_q, rsp_hit_d;
    logic [NUM_BITS-1:0]  rsp_data_q, rsp_data_d;

    logic                 accept;
    logic [NUM_CELLS-1:0] match_vec;
    logic [NUM_CELLS-1:0] first_oh;
    logic [NUM_CELLS-1:0] search_tags;
    logic [NUM_BITS-1:0]  read_word;

`ifdef CAP_MATCH_COUNT_EN
    logic [CNT_W-1:0]     rsp_count_q, rsp_count_d;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CELLS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction
`endif

    // -------------------------------------------------------------------------
    // Shared combinational datapath
    // -------------------------------------------------------------------------
    assign accept      = cmd_valid && cmd_ready;
    // Isolate the lowest set bit: x & -x.
    assign first_oh    = tags_q & (~tags_q + NUM_CELLS'(1));
    assign search_tags = tags_q & match_q;

    always_comb begin
        match_vec = '0;
        read_word = '0;
        for (int unsigned i = 0; i < NUM_CELLS; i++) begin
            match_vec[i] = (((cells_q[i] ^ cmd_data) & cmd_mask) == '0);
            // first_oh is one-hot or zero, so OR-reduction selects one word.
            if (first_oh[i]) begin
                read_word = read_word | cells_q[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && cmd_op == OpSearch) begin
                    state_d = StUpd;
                end
            end
            StUpd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = !RST && (state_q == StIdle);
        busy      = (state_q == StUpd);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        tags_d      = tags_q;
        match_d     = match_q;
        cells_d     = cells_q;
        rsp_valid_d = 1'b0;
        rsp_hit_d   = rsp_hit_q;
        rsp_data_d  = rsp_data_q;
`ifdef CAP_MATCH_COUNT_EN
        rsp_count_d = rsp_count_q;
`endif

        if (state_q == StUpd) begin
            // Second SEARCH stage: narrow the tags with the registered match.
            tags_d      = search_tags;
            rsp_valid_d = 1'b1;
            rsp_hit_d   = |search_tags;
            rsp_data_d  = '0;
`ifdef CAP_MATCH_COUNT_EN
            rsp_count_d = popcount(search_tags);
`endif
        end else if (accept) begin
            case (cmd_op)
                OpSetTags:  tags_d  = '1;
                OpClrTags:  tags_d  = '0;
                OpSearch:   match_d = match_vec;
                OpSelFirst: tags_d  = first_oh;
                OpWrite: begin
                    for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                        if (tags_q[i]) begin
                            cells_d[i] = (cells_q[i] & ~cmd_mask) | (cmd_data & cmd_mask);
                        end
                    end
                end
                OpRead: begin
                    rsp_valid_d = 1'b1;
                    rsp_hit_d   = |tags_q;
                    rsp_data_d  = read_word;
`ifdef CAP_MATCH_COUNT_EN
                    rsp_count_d = popcount(tags_q);
`endif
                end
                // NOP and reserved opcode: accepted, no effect.
                OpNop:   ;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            tags_q      <= '0;
            match_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                cells_q[i] <= '0;
            end
        end else begin
            tags_q      <= tags_d;
            match_q     <= match_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
            for (int unsigned i = 0; i < NUM_CELLS; i++) begin
                cells_q[i] <= cells_d[i];
            end
        end
    end

`ifdef CAP_MATCH_COUNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_count_q <= '0;
        end else begin
            rsp_count_q <= rsp_count_d;
        end
    end

    assign rsp_count = rsp_count_q;
`else
    assign rsp_count = '0;
`endif

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_data  = rsp_data_q;
    assign tag_wires = tags_q;

endmodule
